// File: rtl/saph_pixel_packer_if.sv
// Pixel format types and the handshake bundle between fragment shading,
// the pixel packer and the framebuffer write port.
package saph_pixel_packer_pkg;
  typedef logic [15:0] pixpos_t;

  // width holds N-1, so a field is 1..8 bits wide
  typedef struct packed {
    logic [5:0] pos;
    logic [2:0] width;
  } chfmt_t;

  typedef struct packed {
    logic [3:0] cat;
    logic [5:0] size;
    chfmt_t     a;
    chfmt_t     r;
    chfmt_t     g;
    chfmt_t     b;
  } pixfmt_t;
endpackage

interface saph_pixel_packer_if #(
  parameter int CH_BITS = 8,
  parameter int OUT_W   = 32
);
  saph_pixel_packer_pkg::pixfmt_t fmt;
  logic                           in_valid;
  logic                           in_ready;
  logic [4*CH_BITS-1:0]           in_col;
  saph_pixel_packer_pkg::pixpos_t in_x;
  saph_pixel_packer_pkg::pixpos_t in_y;
  logic                           out_valid;
  logic                           out_ready;
  logic [OUT_W-1:0]               out_data;

  modport master (
    output fmt, in_valid, in_col, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  fmt, in_valid, in_col, in_x, in_y, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/saph_pixel_packer.sv
// Two-stage ARGB -> packed framebuffer word converter (quantise, then pack).
// Define SAPH_PACK_DITHER_EN to add 4x4 Bayer ordered dither before truncation.
module saph_pixel_packer
  import saph_pixel_packer_pkg::*;
#(
  parameter int CH_BITS = 8,
  parameter int OUT_W   = 32
) (
  input logic              clk,
  input logic              rst,
  saph_pixel_packer_if.slave bus
);

  localparam int WIDE = (OUT_W > 72) ? OUT_W : 72;

  logic             s1_valid;
  logic [3:0][7:0]  s1_q;
  logic [3:0][5:0]  s1_pos;
  logic [5:0]       s1_size;
  logic             s2_valid;
  logic [OUT_W-1:0] s2_data;

  logic             s1_adv;
  logic             s2_adv;
  logic [3:0][2:0]  in_width;
  logic [3:0][7:0]  q_next;
  logic [WIDE-1:0]  acc;
  logic [WIDE-1:0]  mask;
  logic [WIDE-1:0]  acc_masked;
  logic             unused_bits;

  // q is right-aligned in 8 bits; widening replicates the channel MSBs downward
  function automatic logic [7:0] quantise(input logic [CH_BITS-1:0] ch,
                                          input logic [2:0]         width);
    logic [7:0]  q;
    logic [15:0] rep;
    int          n;
    q   = '0;
    rep = '0;
    n   = int'(width) + 1;
    if (n <= CH_BITS) begin
      q = 8'(ch >> (CH_BITS - n));
    end else begin
      for (int i = 0; i < 16; i++)
        rep[15-i] = ch[CH_BITS-1-(i % CH_BITS)];
      q = rep[15:8] >> (8 - n);
    end
    return q;
  endfunction

`ifdef SAPH_PACK_DITHER_EN
  localparam logic [8:0] CH_MAX = 9'((1 << CH_BITS) - 1);

  logic [3:0] bayer_m;

  function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
    logic [3:0] m;
    m = '0;
    case ({y, x})
      4'h0: m = 4'd0;   4'h1: m = 4'd8;   4'h2: m = 4'd2;   4'h3: m = 4'd10;
      4'h4: m = 4'd12;  4'h5: m = 4'd4;   4'h6: m = 4'd14;  4'h7: m = 4'd6;
      4'h8: m = 4'd3;   4'h9: m = 4'd11;  4'hA: m = 4'd1;   4'hB: m = 4'd9;
      4'hC: m = 4'd15;  4'hD: m = 4'd7;   4'hE: m = 4'd13;  4'hF: m = 4'd5;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Threshold scaled to the dropped LSBs; saturate instead of wrapping to black
  function automatic logic [CH_BITS-1:0] dither(input logic [CH_BITS-1:0] ch,
                                                input logic [2:0]         width,
                                                input logic [3:0]         m);
    logic [CH_BITS-1:0] res;
    logic [11:0]        t;
    logic [8:0]         sum;
    int                 n;
    res = ch;
    t   = '0;
    sum = '0;
    n   = int'(width) + 1;
    if (n < CH_BITS) begin
      t   = 12'(m) << (CH_BITS - n);
      sum = 9'(ch) + 9'(t >> 4);
      res = (sum > CH_MAX) ? CH_MAX[CH_BITS-1:0] : sum[CH_BITS-1:0];
    end
    return res;
  endfunction

  assign bayer_m = bayer(bus.in_y[1:0], bus.in_x[1:0]);
`endif

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;

  assign in_width = {bus.fmt.a.width, bus.fmt.r.width, bus.fmt.g.width, bus.fmt.b.width};

  // Stage 1 datapath: per-channel quantisation of the incoming colour
  always_comb begin
    q_next = '0;
    for (int c = 0; c < 4; c++) begin
`ifdef SAPH_PACK_DITHER_EN
      q_next[c] = quantise(dither(bus.in_col[c*CH_BITS +: CH_BITS], in_width[c], bayer_m),
                           in_width[c]);
`else
      q_next[c] = quantise(bus.in_col[c*CH_BITS +: CH_BITS], in_width[c]);
`endif
    end
  end

  // Stage 2 datapath: overlapping fields OR together, then clip above size
  always_comb begin
    acc = '0;
    for (int c = 0; c < 4; c++)
      acc = acc | (WIDE'(s1_q[c]) << s1_pos[c]);
    mask       = (WIDE'(2) << s1_size) - WIDE'(1);
    acc_masked = acc & mask;
  end

  // Stage 1 register: captures the format alongside the pixel so it may change every beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_pos   <= '0;
      s1_size  <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_q    <= q_next;
        s1_pos  <= {bus.fmt.a.pos, bus.fmt.r.pos, bus.fmt.g.pos, bus.fmt.b.pos};
        s1_size <= bus.fmt.size;
      end
    end
  end

  // Stage 2 register doubles as the output holding register during back-pressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_data <= acc_masked[OUT_W-1:0];
    end
  end

  assign unused_bits = ^{bus.fmt.cat, bus.in_x, bus.in_y, acc_masked};

endmodule

// File: tb/tb_saph_pixel_packer.sv
// Scoreboard bench for saph_pixel_packer: directed vectors queued on accept,
// a negedge monitor pops and compares every emitted word.
module tb_saph_pixel_packer;
  import saph_pixel_packer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  saph_pixel_packer_if #(.CH_BITS(8), .OUT_W(32)) bus ();

  saph_pixel_packer #(.CH_BITS(8), .OUT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] sb_q[$];
  pixfmt_t     fmt_565;
  pixfmt_t     fmt_8888;

`ifdef SAPH_PACK_DITHER_EN
  localparam logic [31:0] EXP_R07 = 32'h0000_0800;
`else
  localparam logic [31:0] EXP_R07 = 32'h0000_0000;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic applyStimulus(input pixfmt_t f, input logic [31:0] col,
                               input logic [15:0] x, input logic [15:0] y,
                               input logic [31:0] exp);
    bit ok;
    ok = 1'b0;
    bus.fmt      = f;
    bus.in_col   = col;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (ok) sb_q.push_back(exp);
    else    checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drainScoreboard(input string name);
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput(name, 32'(sb_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output: got 0x%08h expected no word", bus.out_data);
      end else begin
        checkOutput("out_data", bus.out_data, sb_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] col;
    int          c0;
    pixfmt_t     sw_fmt[6];
    logic [31:0] sw_col[6];
    logic [31:0] sw_exp[6];

    fmt_565  = '0;
    fmt_565.size    = 6'd15;
    fmt_565.a       = '{pos: 6'd16, width: 3'd0};
    fmt_565.r       = '{pos: 6'd11, width: 3'd4};
    fmt_565.g       = '{pos: 6'd5,  width: 3'd5};
    fmt_565.b       = '{pos: 6'd0,  width: 3'd4};
    fmt_8888 = '0;
    fmt_8888.cat    = 4'd3;
    fmt_8888.size   = 6'd31;
    fmt_8888.a      = '{pos: 6'd24, width: 3'd7};
    fmt_8888.r      = '{pos: 6'd16, width: 3'd7};
    fmt_8888.g      = '{pos: 6'd8,  width: 3'd7};
    fmt_8888.b      = '{pos: 6'd0,  width: 3'd7};

    bus.fmt       = fmt_565;
    bus.in_valid  = 1'b0;
    bus.in_col    = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_data", bus.out_data, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);

    // RGB565 reference pixel and its latency
    applyStimulus(fmt_565, 32'hFFFF_8040, 16'd0, 16'd0, 32'h0000_FC08);
    @(negedge clk);
    checkOutput("latency_cycle1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_cycle2_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;

    // ARGB8888 is an identity mapping; must sustain one pixel per cycle
    c0 = cyc;
    for (int i = 0; i < 1000; i++) begin
      col = $urandom;
      applyStimulus(fmt_8888, col, 16'd0, 16'd0, col);
    end
    checkOutput("argb_throughput_cycles", 32'(cyc - c0), 32'd1000);
    drainScoreboard("argb_drain");

    // Back-pressure: hold output for 5 cycles, the third pixel must wait
    bus.out_ready = 1'b0;
    fork
      begin
        applyStimulus(fmt_565,  32'h1234_5678, 16'd0, 16'd0, 32'h0000_32AF);
        applyStimulus(fmt_8888, 32'hCAFE_BABE, 16'd0, 16'd0, 32'hCAFE_BABE);
        applyStimulus(fmt_565,  32'h00FF_FFFF, 16'd0, 16'd0, 32'h0000_FFFF);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_out_data_held", bus.out_data, 32'h0000_32AF);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drainScoreboard("stall_drain");

    // Reset with both stages full discards the two in-flight pixels
    bus.out_ready = 1'b0;
    applyStimulus(fmt_8888, 32'h1111_1111, 16'd0, 16'd0, 32'h1111_1111);
    applyStimulus(fmt_8888, 32'h2222_2222, 16'd0, 16'd0, 32'h2222_2222);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midreset_out_data", bus.out_data, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    applyStimulus(fmt_565, 32'hFFFF_8040, 16'd0, 16'd0, 32'h0000_FC08);
    @(negedge clk);
    checkOutput("postreset_cycle1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("postreset_cycle2_valid", 32'(bus.out_valid), 32'd1);
    drainScoreboard("reset_drain");

    // Dither threshold at x=0,y=3 (M=15), including saturation
    applyStimulus(fmt_565, 32'h0007_0000, 16'd0, 16'd3, EXP_R07);
    applyStimulus(fmt_565, 32'h00FF_0000, 16'd0, 16'd3, 32'h0000_F800);
    drainScoreboard("dither_drain");

    // Format flips every pixel, back to back
    sw_fmt[0] = fmt_565;  sw_col[0] = 32'h1234_5678; sw_exp[0] = 32'h0000_32AF;
    sw_fmt[1] = fmt_8888; sw_col[1] = 32'hDEAD_BEEF; sw_exp[1] = 32'hDEAD_BEEF;
    sw_fmt[2] = fmt_565;  sw_col[2] = 32'hFFFF_8040; sw_exp[2] = 32'h0000_FC08;
    sw_fmt[3] = fmt_8888; sw_col[3] = 32'h0000_0000; sw_exp[3] = 32'h0000_0000;
    sw_fmt[4] = fmt_565;  sw_col[4] = 32'h00FF_FFFF; sw_exp[4] = 32'h0000_FFFF;
    sw_fmt[5] = fmt_8888; sw_col[5] = 32'h8040_2010; sw_exp[5] = 32'h8040_2010;
    for (int i = 0; i < 6; i++)
      applyStimulus(sw_fmt[i], sw_col[i], 16'd0, 16'd0, sw_exp[i]);
    drainScoreboard("switch_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
